// File: rtl/product_unloader_pkg.sv
// Shared definitions for the multiplier product unloader.
//   DEFAULT_WIDTH : default multiplier operand width (product is 2x this)
//   COUNT_W       : width of the completed-product debug counter
//   state_e       : unloader FSM state encoding
package product_unloader_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int COUNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

endpackage

// File: rtl/product_unloader.sv
// Splits a 2*WIDTH multiplier product into two WIDTH-bit transfers on a
// valid/ready stream: low half first (out_last=0), then high half (out_last=1).
// A new product may be accepted in the same cycle the high half is taken,
// so a continuous stream sustains one product every two cycles.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   product_in  : full 2*WIDTH product      in_valid / in_ready : input handshake
//   data_out    : one product half          out_valid / out_ready : output handshake
//   out_last    : marks the high half (final transfer of a product)
module product_unloader
  import product_unloader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] product_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   held_q, held_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  // Debug only: completed products (high halves taken), wraps naturally.
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 accept;

  // in_ready is held low while reset is asserted so nothing is accepted
  // regardless of the (possibly stale) state.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    in_ready = 1'b1;
        SEND_HI: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;

    unique case (state_q)
      IDLE: ;
      SEND_LO: begin
        if (out_ready) begin
          state_d    = SEND_HI;
          data_out_d = held_q[2*WIDTH-1:WIDTH];
          out_last_d = 1'b1;
        end else begin
          data_out_d = held_q[WIDTH-1:0];
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          count_d     = count_q + 1'b1;
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    // Accept overrides the above: from IDLE, or back-to-back from SEND_HI
    // as the high half leaves (accept there implies out_ready).
    if (accept) begin
      state_d     = SEND_LO;
      held_d      = product_in;
      data_out_d  = product_in[WIDTH-1:0];
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      held_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_product_unloader.sv
module tb_product_unloader;

  localparam int W = 64;

  logic           clk;
  logic           reset;
  logic [2*W-1:0] product_in;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   data_out;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  product_unloader #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .product_in(product_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           iv;
    logic [2*W-1:0] prod;
    logic           ordy;
    logic           e_ir;   // in_ready before the edge
    logic           e_ov;   // outputs after the edge
    logic           e_ol;
    logic [W-1:0]   e_do;
    logic           c_do;   // compare data_out
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic rst, input logic iv, input logic [2*W-1:0] prod,
                      input logic ordy, input logic e_ir, input logic e_ov,
                      input logic e_ol, input logic [W-1:0] e_do, input logic c_do);
    vec_t v;
    v = '{rst, iv, prod, ordy, e_ir, e_ov, e_ol, e_do, c_do};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cyc(input logic rst, input logic iv, input logic [2*W-1:0] prod,
                     input logic ordy);
    reset = rst; in_valid = iv; product_in = prod; out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [2*W-1:0] P35  = {64'h3, 64'h5};
  localparam logic [2*W-1:0] P76  = {64'h77, 64'h66};
  localparam logic [2*W-1:0] PJNK = {64'hDEAD_BEEF_0000_1111, 64'hCAFE_F00D_2222_3333};
  localparam logic [2*W-1:0] P12  = {64'h1, 64'h2};
  localparam logic [2*W-1:0] PAB  = {64'hA, 64'hB};
  localparam logic [2*W-1:0] PFF  = {2*W{1'b1}};
  localparam logic [2*W-1:0] P98  = {64'h9, 64'h8};
  localparam logic [W-1:0]   ALL1 = {W{1'b1}};

  initial begin
    reset = 1'b1; in_valid = 1'b0; product_in = '0; out_ready = 1'b0;

    //    rst iv prod  ordy | ir ov ol do      c_do
    addv(1, 0, '0,   0,     0, 0, 0, 64'h0,  1);  // reset state
    addv(0, 0, '0,   0,     1, 0, 0, 64'h0,  0);  // in_ready up after reset
    // single product, out_ready high
    addv(0, 1, P35,  1,     1, 1, 0, 64'h5,  1);
    addv(0, 0, '0,   1,     0, 1, 1, 64'h3,  1);
    addv(0, 0, '0,   1,     1, 0, 0, 64'h0,  0);
    // stall 3 cycles in SEND_LO; junk input ignored
    addv(0, 1, P76,  0,     1, 1, 0, 64'h66, 1);
    addv(0, 1, PJNK, 0,     0, 1, 0, 64'h66, 1);
    addv(0, 1, PJNK, 0,     0, 1, 0, 64'h66, 1);
    addv(0, 1, PJNK, 0,     0, 1, 0, 64'h66, 1);
    addv(0, 0, '0,   1,     0, 1, 1, 64'h77, 1);
    addv(0, 1, PJNK, 0,     0, 1, 1, 64'h77, 1);  // stall in SEND_HI
    addv(0, 0, '0,   1,     1, 0, 0, 64'h0,  0);
    // back-to-back products
    addv(0, 1, P12,  1,     1, 1, 0, 64'h2,  1);
    addv(0, 1, PAB,  1,     0, 1, 1, 64'h1,  1);
    addv(0, 1, PAB,  1,     1, 1, 0, 64'hB,  1);
    addv(0, 0, '0,   1,     0, 1, 1, 64'hA,  1);
    addv(0, 0, '0,   1,     1, 0, 0, 64'h0,  0);  // out_ready while idle
    // zero product
    addv(0, 1, '0,   1,     1, 1, 0, 64'h0,  1);
    addv(0, 0, '0,   1,     0, 1, 1, 64'h0,  1);
    addv(0, 0, '0,   1,     1, 0, 0, 64'h0,  0);
    // reset in SEND_HI of all-ones product
    addv(0, 1, PFF,  1,     1, 1, 0, ALL1,   1);
    addv(0, 0, '0,   1,     0, 1, 1, ALL1,   1);
    addv(1, 1, P35,  1,     0, 0, 0, 64'h0,  1);
    addv(0, 0, '0,   1,     1, 0, 0, 64'h0,  0);
    // reset in SEND_LO
    addv(0, 1, P98,  1,     1, 1, 0, 64'h8,  1);
    addv(1, 0, '0,   0,     0, 0, 0, 64'h0,  1);
    addv(0, 0, '0,   1,     1, 0, 0, 64'h0,  0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; in_valid = vq[i].iv;
      product_in = vq[i].prod; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), {63'b0, in_ready}, {63'b0, vq[i].e_ir});
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), {63'b0, out_valid}, {63'b0, vq[i].e_ov});
      chk($sformatf("v%0d out_last", i), {63'b0, out_last}, {63'b0, vq[i].e_ol});
      if (vq[i].c_do) chk($sformatf("v%0d data_out", i), data_out, vq[i].e_do);
      @(negedge clk);
    end

    // debug count: reset at the last table row, then three products streamed
    for (int k = 0; k < 6; k++) cyc(0, 1, P12, 1);
    cyc(0, 0, '0, 1);
    chk("count after 3", {48'b0, dut.count_q}, 64'd3);
    chk("idle after stream", {63'b0, out_valid}, 64'd0);

    // wrap: preload near the top, then deliver two more products
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    cyc(0, 1, PAB, 1);
    cyc(0, 1, PAB, 1);
    cyc(0, 1, PAB, 1);
    chk("count at ffff", {48'b0, dut.count_q}, 64'hFFFF);
    cyc(0, 1, PAB, 1);
    cyc(0, 0, '0, 1);
    chk("count wraps", {48'b0, dut.count_q}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/product_unloader.md
PRODUCT_UNLOADER -- requirements
Module: product_unloader

Interface
REQ-001 Parameter WIDTH, default 64, SHALL be the multiplier operand width; the product is 2*WIDTH bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset.
REQ-004 product_in  input  2*WIDTH  SHALL carry the full multiplier product.
REQ-005 in_valid  input  1  SHALL indicate product_in holds a valid product.
REQ-006 in_ready  output  1  SHALL indicate the block accepts product_in this cycle.
REQ-007 data_out  output  WIDTH  SHALL carry one product half per transfer.
REQ-008 out_valid  output  1  SHALL indicate data_out holds a valid half.
REQ-009 out_last  output  1  SHALL mark the high half, the final transfer of a product.
REQ-010 out_ready  input  1  SHALL indicate the downstream consumer accepts data_out this cycle.

Function
REQ-011 A product SHALL be accepted on a cycle where in_valid && in_ready.
REQ-012 The accepted product SHALL be captured into an internal 2*WIDTH holding register on the same edge.
REQ-013 FSM states SHALL be IDLE, SEND_LO, SEND_HI.
REQ-014 IDLE: out_valid=0, in_ready=1; on accept -> SEND_LO.
REQ-015 SEND_LO: out_valid=1, data_out=held[WIDTH-1:0], out_last=0, in_ready=0; on out_ready -> SEND_HI, else hold.
REQ-016 SEND_HI: out_valid=1, data_out=held[2*WIDTH-1:WIDTH], out_last=1; in_ready=out_ready.
REQ-017 SEND_HI with out_ready and in_valid SHALL capture the new product and go to SEND_LO (back-to-back, no bubble).
REQ-018 SEND_HI with out_ready and !in_valid SHALL go to IDLE.
REQ-019 Latency SHALL be one cycle: the low half is valid on the cycle after accept.
REQ-020 Steady-state throughput SHALL be one product per two cycles when out_ready is held high.
REQ-021 data_out, out_last and out_valid SHALL be registered and stable while out_valid && !out_ready.
REQ-022 in_valid without in_ready SHALL have no effect; product_in is ignored outside accept cycles.
REQ-023 A product of zero SHALL be transferred as two zero words like any other value.
REQ-024 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-025 A 16-bit internal count of completed products SHALL increment on each accepted high-half transfer and wrap from 0xFFFF to 0x0000; it is a debug register and not a port.

Reset
REQ-026 reset SHALL force state IDLE, out_valid=0, out_last=0, data_out=0, holding register=0, count=0.
REQ-027 in_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted in SEND_LO or SEND_HI SHALL discard the partial product with no further transfer.
REQ-029 Reset SHALL take priority over any simultaneous accept or transfer.

Structure
REQ-030 State encoding (IDLE, SEND_LO, SEND_HI) and the WIDTH default SHALL live in the shared multiplier package.
REQ-031 The design SHALL be one module with no sub-modules; the holding register is inline.

Verification
REQ-032 Single product 0x0000000000000003_0000000000000005 with out_ready=1 -> data_out 0x5 (out_last=0), next cycle 0x3 (out_last=1), then IDLE.
REQ-033 Hold out_ready=0 for 3 cycles in SEND_LO -> data_out, out_valid, out_last unchanged for all 3 cycles; low half accepted when out_ready rises.
REQ-034 Two products 0x1_2 and 0xA_B presented continuously with out_ready=1 -> transfers 0x2, 0x1, 0xB, 0xA on four consecutive cycles; in_ready high only in the SEND_HI cycles.
REQ-035 Reset asserted in SEND_HI of product 0xFFFF..FF -> next cycle out_valid=0, state IDLE, no high half delivered.
REQ-036 Product of all zeros -> two transfers of 0x0, second with out_last=1.
REQ-037 65536 products delivered -> debug count returns to 0x0000.
